// File: rtl/bus_control_sequencer.sv
// Timing-and-control sequencer for the basic computer's common bus.
// Each timing step T0..T6 runs a SEL clock (bus source chosen) and an LD clock (strobes fire).
module bus_control_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RUN,
  input  logic [15:0] IR,
  input  logic        DR_ZERO,
  output logic [7:0]  selection,
  output logic        AR_LD,
  output logic        AR_INR,
  output logic        PC_LD,
  output logic        PC_INR,
  output logic        DR_LD,
  output logic        DR_INR,
  output logic        IR_LD,
  output logic        AC_LD,
  output logic        MEM_WR,
  output logic [1:0]  ALU_OP,
  output logic        REG_EXEC,
  output logic [2:0]  SC,
  output logic        PHASE,
  output logic        HALTED
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEL, ST_LD} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sc_q, sc_d;
  logic        halted_q, halted_d;
  logic [2:0]  d_q;
  logic        i_q;
  logic        hlt_q;
  logic        latch_op;
  logic        last_step;
  logic        ld;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      sc_q     <= 3'd0;
      halted_q <= 1'b0;
      d_q      <= 3'd0;
      i_q      <= 1'b0;
      hlt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      halted_q <= halted_d;
      if (latch_op) begin
        d_q   <= IR[14:12];
        i_q   <= IR[15];
        hlt_q <= (IR == 16'h7001);
      end
    end
  end

  // Final step of the current instruction, by opcode.
  always_comb begin
    last_step = 1'b0;
    case (sc_q)
      3'd3:    last_step = (d_q == 3'd7);
      3'd4:    last_step = (d_q == 3'd3) || (d_q == 3'd4);
      3'd5:    last_step = (d_q <= 3'd2) || (d_q == 3'd5);
      3'd6:    last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    halted_d = halted_q;
    latch_op = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RUN) begin
          state_d  = ST_SEL;
          sc_d     = 3'd0;
          halted_d = 1'b0;
        end
      end
      ST_SEL: begin
        state_d  = ST_LD;
        latch_op = (sc_q == 3'd2);
      end
      ST_LD: begin
        state_d = ST_SEL;
        if (last_step) begin
          sc_d = 3'd0;
          if ((sc_q == 3'd3) && hlt_q) begin
            state_d  = ST_IDLE;
            halted_d = 1'b1;
          end
        end else begin
          sc_d = sc_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sc_d    = 3'd0;
      end
    endcase
  end

  assign ld     = (state_q == ST_LD);
  assign SC     = sc_q;
  assign PHASE  = ld;
  assign HALTED = halted_q;

  // Source is decoded from the step alone; strobes are qualified by the LD phase.
  always_comb begin
    selection = 8'd0;
    AR_LD     = 1'b0;
    AR_INR    = 1'b0;
    PC_LD     = 1'b0;
    PC_INR    = 1'b0;
    DR_LD     = 1'b0;
    DR_INR    = 1'b0;
    IR_LD     = 1'b0;
    AC_LD     = 1'b0;
    MEM_WR    = 1'b0;
    ALU_OP    = 2'b00;
    REG_EXEC  = 1'b0;
    if (state_q != ST_IDLE) begin
      case (sc_q)
        3'd0: begin selection = 8'd4;   AR_LD = ld; end
        3'd1: begin selection = 8'd128; IR_LD = ld; PC_INR = ld; end
        3'd2: begin selection = 8'd32;  AR_LD = ld; end
        3'd3: begin
          if (d_q == 3'd7) begin
            REG_EXEC = ld & ~hlt_q;
          end else if (i_q) begin
            selection = 8'd128;
            AR_LD     = ld;
          end
        end
        3'd4: begin
          case (d_q)
            3'd0, 3'd1, 3'd2, 3'd6: begin selection = 8'd128; DR_LD = ld; end
            3'd3:    begin selection = 8'd16; MEM_WR = ld; end
            3'd4:    begin selection = 8'd2;  PC_LD = ld; end
            3'd5:    begin selection = 8'd4;  MEM_WR = ld; AR_INR = ld; end
            default: selection = 8'd0;
          endcase
        end
        3'd5: begin
          case (d_q)
            3'd0:    begin AC_LD = ld; ALU_OP = 2'b00; end
            3'd1:    begin AC_LD = ld; ALU_OP = {1'b0, ld}; end
            3'd2:    begin AC_LD = ld; ALU_OP = {ld, 1'b0}; end
            3'd5:    begin selection = 8'd2; PC_LD = ld; end
            3'd6:    DR_INR = ld;
            default: selection = 8'd0;
          endcase
        end
        3'd6: begin selection = 8'd8; MEM_WR = ld; PC_INR = ld & DR_ZERO; end
        default: selection = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Bench for bus_control_sequencer: an instruction-level model expands each opcode
// into its list of micro-steps and is compared against the DUT every cycle.
module tb_bus_control_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RUN = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        DR_ZERO = 1'b0;
  logic [7:0]  selection;
  logic        AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR, IR_LD, AC_LD, MEM_WR;
  logic [1:0]  ALU_OP;
  logic        REG_EXEC;
  logic [2:0]  SC;
  logic        PHASE, HALTED;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  bus_control_sequencer dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .IR(IR), .DR_ZERO(DR_ZERO),
    .selection(selection),
    .AR_LD(AR_LD), .AR_INR(AR_INR), .PC_LD(PC_LD), .PC_INR(PC_INR),
    .DR_LD(DR_LD), .DR_INR(DR_INR), .IR_LD(IR_LD), .AC_LD(AC_LD), .MEM_WR(MEM_WR),
    .ALU_OP(ALU_OP), .REG_EXEC(REG_EXEC), .SC(SC), .PHASE(PHASE), .HALTED(HALTED)
  );

  // Strobe vector bit positions
  localparam logic [9:0] X_ARLD  = 10'b1000000000;
  localparam logic [9:0] X_ARINR = 10'b0100000000;
  localparam logic [9:0] X_PCLD  = 10'b0010000000;
  localparam logic [9:0] X_PCINR = 10'b0001000000;
  localparam logic [9:0] X_DRLD  = 10'b0000100000;
  localparam logic [9:0] X_DRINR = 10'b0000010000;
  localparam logic [9:0] X_IRLD  = 10'b0000001000;
  localparam logic [9:0] X_ACLD  = 10'b0000000100;
  localparam logic [9:0] X_MEMWR = 10'b0000000010;
  localparam logic [9:0] X_REGX  = 10'b0000000001;

  logic [9:0] dut_stb;
  assign dut_stb = {AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR, IR_LD, AC_LD, MEM_WR, REG_EXEC};

  typedef struct packed {
    logic [7:0] sel;
    logic [9:0] stb;
    logic [1:0] alu;
    logic [2:0] sc;
    logic       ph;
    logic       dzdep;
  } cyc_t;

  cyc_t        mq[$];
  bit          m_idle = 1'b1;
  bit          m_halted = 1'b0;
  logic [15:0] m_ir = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void push_step(input logic [2:0] sc, input logic [7:0] sel,
                                    input logic [9:0] stb, input logic [1:0] alu, input logic dzdep);
    cyc_t c;
    c.sel = sel; c.stb = 10'd0; c.alu = 2'd0; c.sc = sc; c.ph = 1'b0; c.dzdep = 1'b0;
    mq.push_back(c);
    c.stb = stb; c.alu = alu; c.ph = 1'b1; c.dzdep = dzdep;
    mq.push_back(c);
  endfunction

  function automatic void push_fetch();
    push_step(3'd0, 8'd4,   X_ARLD, 2'd0, 1'b0);
    push_step(3'd1, 8'd128, X_IRLD | X_PCINR, 2'd0, 1'b0);
    push_step(3'd2, 8'd32,  X_ARLD, 2'd0, 1'b0);
  endfunction

  function automatic void push_exec(input logic [15:0] ir);
    logic [2:0] d;
    d = ir[14:12];
    if (d == 3'd7) begin
      push_step(3'd3, 8'd0, (ir == 16'h7001) ? 10'd0 : X_REGX, 2'd0, 1'b0);
    end else begin
      push_step(3'd3, ir[15] ? 8'd128 : 8'd0, ir[15] ? X_ARLD : 10'd0, 2'd0, 1'b0);
      case (d)
        3'd0: begin push_step(3'd4, 8'd128, X_DRLD, 2'd0, 1'b0); push_step(3'd5, 8'd0, X_ACLD, 2'b00, 1'b0); end
        3'd1: begin push_step(3'd4, 8'd128, X_DRLD, 2'd0, 1'b0); push_step(3'd5, 8'd0, X_ACLD, 2'b01, 1'b0); end
        3'd2: begin push_step(3'd4, 8'd128, X_DRLD, 2'd0, 1'b0); push_step(3'd5, 8'd0, X_ACLD, 2'b10, 1'b0); end
        3'd3: push_step(3'd4, 8'd16, X_MEMWR, 2'd0, 1'b0);
        3'd4: push_step(3'd4, 8'd2, X_PCLD, 2'd0, 1'b0);
        3'd5: begin
          push_step(3'd4, 8'd4, X_MEMWR | X_ARINR, 2'd0, 1'b0);
          push_step(3'd5, 8'd2, X_PCLD, 2'd0, 1'b0);
        end
        default: begin
          push_step(3'd4, 8'd128, X_DRLD, 2'd0, 1'b0);
          push_step(3'd5, 8'd0, X_DRINR, 2'd0, 1'b0);
          push_step(3'd6, 8'd8, X_MEMWR, 2'd0, 1'b1);
        end
      endcase
    end
  endfunction

  // Model advance on each rising edge
  initial begin
    cyc_t cur;
    forever begin
      @(posedge CLK);
      if (RST) begin
        m_idle = 1'b1; m_halted = 1'b0; mq.delete();
      end else if (m_idle) begin
        if (RUN) begin
          m_idle = 1'b0; m_halted = 1'b0; push_fetch();
        end
      end else if (mq.size() > 0) begin
        cur = mq.pop_front();
        if (cur.sc == 3'd2 && cur.ph == 1'b0) m_ir = IR;
        if (mq.size() == 0) begin
          if (cur.sc == 3'd2) push_exec(m_ir);
          else if (m_ir == 16'h7001) begin m_idle = 1'b1; m_halted = 1'b1; end
          else push_fetch();
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    cyc_t e;
    forever begin
      @(negedge CLK);
      e = '0;
      if (!m_idle) begin
        if (mq.size() > 0) begin
          e = mq[0];
          if (e.dzdep && DR_ZERO) e.stb = e.stb | X_PCINR;
        end else begin
          chk("model_queue_nonempty", 32'd0, 32'd1);
        end
      end
      chk("selection", selection, e.sel);
      chk("strobes",   dut_stb,   e.stb);
      chk("ALU_OP",    ALU_OP,    e.alu);
      chk("SC",        SC,        e.sc);
      chk("PHASE",     PHASE,     e.ph);
      chk("HALTED",    HALTED,    m_halted);
    end
  end

  logic [15:0] tbl_ir [9];
  logic        tbl_dz [9];
  int          tbl_st [9];

  initial begin
    tbl_ir = '{16'h1123, 16'h8004, 16'h5010, 16'h6020, 16'h6020, 16'h2005, 16'h4007, 16'h7800, 16'h7001};
    tbl_dz = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl_st = '{1, 13, 25, 37, 51, 65, 77, 87, 95};

    repeat (3) @(negedge CLK);
    #1;
    chk("reset_selection", selection, 32'd0);
    chk("reset_strobes",   dut_stb,   32'd0);
    chk("reset_HALTED",    HALTED,    32'd0);
    RST = 1'b0; IR = tbl_ir[0]; RUN = 1'b1;

    for (int cyc = 1; cyc <= 105; cyc++) begin
      @(negedge CLK);
      #1;
      if (cyc == 1) RUN = 1'b0;
      for (int i = 0; i < 9; i++) begin
        if (cyc == tbl_st[i]) DR_ZERO = tbl_dz[i];
        if (cyc == tbl_st[i] + 5 && i < 8) IR = tbl_ir[i + 1];
      end
      case (cyc)
        1:  begin chk("c1_sel", selection, 32'd4); chk("c1_AR_LD", AR_LD, 32'd0); end
        2:  begin chk("c2_sel", selection, 32'd4); chk("c2_AR_LD", AR_LD, 32'd1); end
        3:  begin chk("c3_sel", selection, 32'd128); chk("c3_IR_LD", IR_LD, 32'd0); end
        4:  begin chk("c4_sel", selection, 32'd128); chk("c4_IR_LD", IR_LD, 32'd1); chk("c4_PC_INR", PC_INR, 32'd1); end
        7:  chk("add_T3_sel", selection, 32'd0);
        12: begin chk("add_T5_AC_LD", AC_LD, 32'd1); chk("add_T5_ALU", ALU_OP, 32'd1); end
        13: begin chk("add_next_SC", SC, 32'd0); chk("add_next_PHASE", PHASE, 32'd0); chk("add_next_sel", selection, 32'd4); end
        20: begin chk("and_ind_T3_sel", selection, 32'd128); chk("and_ind_T3_AR_LD", AR_LD, 32'd1); end
        24: begin chk("and_T5_AC_LD", AC_LD, 32'd1); chk("and_T5_ALU", ALU_OP, 32'd0); end
        34: begin chk("bsa_T4_sel", selection, 32'd4); chk("bsa_T4_MEM_WR", MEM_WR, 32'd1); chk("bsa_T4_AR_INR", AR_INR, 32'd1); end
        36: begin chk("bsa_T5_sel", selection, 32'd2); chk("bsa_T5_PC_LD", PC_LD, 32'd1); end
        50: begin chk("isz_z_sel", selection, 32'd8); chk("isz_z_MEM_WR", MEM_WR, 32'd1); chk("isz_z_PC_INR", PC_INR, 32'd1); end
        64: begin chk("isz_nz_MEM_WR", MEM_WR, 32'd1); chk("isz_nz_PC_INR", PC_INR, 32'd0); end
        76: begin chk("lda_T5_AC_LD", AC_LD, 32'd1); chk("lda_T5_ALU", ALU_OP, 32'd2); end
        86: begin chk("bun_T4_sel", selection, 32'd2); chk("bun_T4_PC_LD", PC_LD, 32'd1); end
        94: chk("rr_REG_EXEC", REG_EXEC, 32'd1);
        102: chk("hlt_T3_REG_EXEC", REG_EXEC, 32'd0);
        103: begin chk("hlt_HALTED", HALTED, 32'd1); chk("hlt_sel", selection, 32'd0); chk("hlt_SC", SC, 32'd0); end
        105: begin chk("hlt_stays_idle", dut_stb, 32'd0); chk("hlt_still_HALTED", HALTED, 32'd1); end
        default: ;
      endcase
    end

    RUN = 1'b1; IR = 16'h3009; DR_ZERO = 1'b0;
    @(negedge CLK);
    #1;
    chk("restart_HALTED", HALTED, 32'd0);
    chk("restart_sel", selection, 32'd4);
    RUN = 1'b0;
    repeat (9) @(negedge CLK);
    #1;
    chk("sta_T4_sel", selection, 32'd16);
    chk("sta_T4_MEM_WR", MEM_WR, 32'd1);
    chk("sta_T4_SC", SC, 32'd4);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk("rst_MEM_WR", MEM_WR, 32'd0);
    chk("rst_sel", selection, 32'd0);
    chk("rst_SC", SC, 32'd0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("post_rst_idle_sel", selection, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
